dmem_arbiter: RTL and testbench

Shares the single-port 1 KB data memory between the core load/store port and the AES block engine. The core port issues single-word accesses that complete in the same cycle. The AES port moves 128-bit blocks as locked 4-beat bursts. A starvation guard bounds how long the core can hold off a pending AES request. The block sits between the core/AES units and the data memory, and drives that memory's mem_write, mem_read, addr and wd inputs directly.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter for the single-port data memory: single-cycle core accesses and
// locked 4-beat AES block bursts. A starvation counter bounds the AES wait.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wd,
    output logic         cpu_gnt,
    output logic [31:0]  cpu_rd,
    input  logic         aes_req,
    input  logic         aes_we,
    input  logic [31:0]  aes_addr,
    input  logic [127:0] aes_wblk,
    output logic [127:0] aes_rblk,
    output logic         aes_busy,
    output logic         aes_done,
    output logic         mem_write,
    output logic         mem_read,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wd,
    input  logic [31:0]  mem_rd
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [27:0]    base_q, base_d;
    logic           we_q, we_d;
    logic [127:0]   wblk_q, wblk_d;
    logic [127:0]   rblk_q, rblk_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           core_access;
    logic           cpu_wins;

    // Grants are suppressed while reset is asserted so no access leaks out.
    assign cpu_wins = !rst && cpu_req && (!aes_req || (starve_q < LIMIT));

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        starve_d    = starve_q;
        base_d      = base_q;
        we_d        = we_q;
        wblk_d      = wblk_q;
        rblk_d      = rblk_q;
        core_access = 1'b0;
        cpu_gnt     = 1'b0;
        cpu_rd      = 32'd0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        mem_addr    = 32'd0;
        mem_wd      = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (cpu_wins) begin
                    core_access = 1'b1;
                    if (aes_req && (starve_q != LIMIT)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (aes_req && !rst) begin
                    base_d   = aes_addr[31:4];
                    we_d     = aes_we;
                    wblk_d   = aes_wblk;
                    beat_d   = 2'd0;
                    starve_d = '0;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                // Beat index replaces address bits [3:2]; the burst never leaves its block.
                mem_addr = {base_q, beat_q, 2'b00};
                if (we_q) begin
                    mem_write = 1'b1;
                    mem_wd    = wblk_q[{beat_q, 5'd0} +: 32];
                end else begin
                    mem_read = 1'b1;
                    rblk_d[{beat_q, 5'd0} +: 32] = mem_rd;
                end
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                core_access = cpu_req && !rst;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (core_access) begin
            cpu_gnt   = 1'b1;
            mem_addr  = cpu_addr;
            mem_wd    = cpu_wd;
            mem_write = cpu_we;
            mem_read  = !cpu_we;
            cpu_rd    = cpu_we ? 32'd0 : mem_rd;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= 2'd0;
            starve_q <= '0;
            base_q   <= 28'd0;
            we_q     <= 1'b0;
            wblk_q   <= 128'd0;
            rblk_q   <= 128'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
            base_q   <= base_d;
            we_q     <= we_d;
            wblk_q   <= wblk_d;
            rblk_q   <= rblk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign aes_rblk = rblk_q;
    assign aes_busy = busy_q;
    assign aes_done = done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1 KB memory attached.
module tb_dmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr, cpu_wd;
    logic         cpu_gnt;
    logic [31:0]  cpu_rd;
    logic         aes_req, aes_we;
    logic [31:0]  aes_addr;
    logic [127:0] aes_wblk, aes_rblk;
    logic         aes_busy, aes_done;
    logic         mem_write, mem_read;
    logic [31:0]  mem_addr, mem_wd, mem_rd;

    logic [31:0]  mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_gnt(cpu_gnt), .cpu_rd(cpu_rd),
        .aes_req(aes_req), .aes_we(aes_we), .aes_addr(aes_addr), .aes_wblk(aes_wblk),
        .aes_rblk(aes_rblk), .aes_busy(aes_busy), .aes_done(aes_done),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] blk;
        logic [127:0] blk2;
        logic [31:0]  w;
        int           busy_cnt;
        bit           exp_g [9];

        blk  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        blk2 = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h80] = 32'hA0A0A0A0; mem[8'h81] = 32'hA1A1A1A1;
        mem[8'h82] = 32'hA2A2A2A2; mem[8'h83] = 32'hA3A3A3A3;

        rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
        aes_req = 0; aes_we = 0; aes_addr = 0; aes_wblk = 0;
        tick; tick;
        #1;
        check("rst_gnt", cpu_gnt, 1'b0);
        check("rst_busy", aes_busy, 1'b0);
        check("rst_done", aes_done, 1'b0);
        check("rst_rblk", aes_rblk, 128'd0);
        check("rst_memwr", {mem_write, mem_read}, 2'b00);
        check("rst_memaddr", mem_addr, 32'd0);
        rst = 1'b0;
        tick;

        // core store then load
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wd = 32'hDEADBEEF;
        #1;
        check("st_gnt", cpu_gnt, 1'b1);
        check("st_mem", {mem_write, mem_read, mem_addr, mem_wd}, {2'b10, 32'h10, 32'hDEADBEEF});
        check("st_rd0", cpu_rd, 32'd0);
        tick;
        cpu_we = 0;
        #1;
        check("ld_gnt", cpu_gnt, 1'b1);
        check("ld_memrd", {mem_write, mem_read}, 2'b01);
        check("ld_data", cpu_rd, 32'hDEADBEEF);
        check("ld_aes", {aes_busy, aes_done, aes_rblk}, 130'd0);
        tick;
        cpu_req = 0;

        // AES block store, low address bits ignored
        aes_req = 1; aes_we = 1; aes_addr = 32'h104; aes_wblk = blk;
        #1;
        check("as_acc_gnt", cpu_gnt, 1'b0);
        check("as_acc_mem", {mem_write, mem_read}, 2'b00);
        for (int k = 0; k < 4; k++) begin
            tick;
            w = blk[k*32 +: 32];
            check($sformatf("as_beat%0d_busy", k), aes_busy, 1'b1);
            check($sformatf("as_beat%0d", k), {mem_write, mem_addr, mem_wd},
                  {1'b1, 32'h100 + 32'(4 * k), w});
        end
        tick;
        aes_req = 0;
        check("as_done", {aes_done, aes_busy}, 2'b11);
        tick;
        check("as_idle", {aes_done, aes_busy}, 2'b00);
        cpu_req = 1; cpu_we = 0;
        for (int k = 0; k < 4; k++) begin
            cpu_addr = 32'h100 + 32'(4 * k);
            w = blk[k*32 +: 32];
            #1;
            check($sformatf("as_readback%0d", k), cpu_rd, w);
            tick;
        end
        cpu_req = 0;

        // AES block load with a core request arriving mid-burst
        aes_req = 1; aes_we = 0; aes_addr = 32'h100;
        busy_cnt = 0;
        tick;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) begin cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; end
            if (c == 5) aes_req = 0;
            #1;
            if (aes_busy) busy_cnt++;
            if (c <= 4) begin
                check($sformatf("al_beat%0d", c - 1), {mem_read, mem_write, mem_addr},
                      {2'b10, 32'h100 + 32'(4 * (c - 1))});
                check($sformatf("al_blk_gnt%0d", c), cpu_gnt, 1'b0);
            end else if (c == 5) begin
                check("al_done", aes_done, 1'b1);
                check("al_rblk", aes_rblk, blk);
                check("al_done_gnt", {cpu_gnt, mem_addr, cpu_rd}, {1'b1, 32'h10, 32'hDEADBEEF});
            end else begin
                check("al_after", {aes_done, aes_busy}, 2'b00);
                check("al_rblk_hold", aes_rblk, blk);
            end
            tick;
        end
        cpu_req = 0;
        check("al_busy_cycles", busy_cnt, 5);

        // starvation guard, both requests held from reset
        rst = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        aes_req = 1; aes_we = 0; aes_addr = 32'h100;
        #1;
        check("sv_rst_gnt", cpu_gnt, 1'b0);
        check("sv_rst_rblk", aes_rblk, 128'd0);
        tick;
        rst = 0;
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 9; c++) begin
            if (c == 8) aes_req = 0;
            #1;
            check($sformatf("sv_gnt%0d", c), cpu_gnt, exp_g[c]);
            if (c == 8) check("sv_done", aes_done, 1'b1);
            tick;
        end
        cpu_req = 0;

        // reset during beat 2 of a store
        aes_req = 1; aes_we = 1; aes_addr = 32'h200; aes_wblk = blk2;
        tick;
        aes_req = 0;
        tick; tick;
        check("rb_beat2", {mem_write, mem_addr}, {1'b1, 32'h208});
        rst = 1;
        #1;
        check("rb_outs", {aes_busy, aes_done, mem_write, mem_read}, 4'b0000);
        check("rb_addr", mem_addr, 32'd0);
        check("rb_rblk", aes_rblk, 128'd0);
        tick;
        rst = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("rb_nodone%0d", c), {aes_done, aes_busy}, 2'b00);
            tick;
        end
        cpu_req = 1; cpu_we = 0;
        for (int k = 0; k < 4; k++) begin
            cpu_addr = 32'h200 + 32'(4 * k);
            w = (k < 2) ? blk2[k*32 +: 32] : ((k == 2) ? 32'hA2A2A2A2 : 32'hA3A3A3A3);
            #1;
            check($sformatf("rb_word%0d", k), cpu_rd, w);
            tick;
        end
        cpu_req = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
